// File: rtl/gb_bus_target.sv
// gb_bus_target: CPU bus responder for the tv80s wrapper.
// Serves work RAM, four I/O registers and the intack vector.
module gb_bus_target #(
  parameter int          ADDR_BITS   = 13,
  parameter logic [15:0] RAM_BASE    = 16'hC000,
  parameter logic [7:0]  IO_BASE     = 8'h00,
  parameter int          WAIT_STATES = 0,
  parameter logic [7:0]  INT_VECTOR  = 8'hFF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        mreq_n,
  input  logic        iorq_n,
  input  logic        rd_n,
  input  logic        wr_n,
  input  logic        m1_n,
  input  logic [15:0] A,
  input  logic [7:0]  cpu_dout,
  output logic [7:0]  di,
  output logic        wait_n,
  output logic [31:0] io_regs
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DONE
  } state_t;

  localparam logic       HAS_WAIT = (WAIT_STATES > 0);
  localparam logic       ONE_WAIT = (WAIT_STATES == 1);
  localparam logic [2:0] CNT_INIT = 3'(WAIT_STATES - 1);

  state_t          state_q;
  logic [2:0]      cnt_q;
  logic [7:0]      mem_q;
  logic [3:0][7:0] io_q;
  logic [7:0]      mem [2**ADDR_BITS];

  logic rd_s;
  logic wr_s;
  logic ram_hit;
  logic io_hit;
  logic ack_hit;
  logic acc;
  logic stall;
  logic commit;

  // Both rd_n and wr_n low is not a legal access.
  assign rd_s = ~rd_n & wr_n;
  assign wr_s = ~wr_n & rd_n;

  assign ram_hit = ~mreq_n & iorq_n &
    (A[15:ADDR_BITS] == RAM_BASE[15:ADDR_BITS]);
  assign io_hit = ~iorq_n & mreq_n & m1_n &
    (A[7:2] == IO_BASE[7:2]);
  assign ack_hit = ~iorq_n & ~m1_n;

  assign acc = (ram_hit | io_hit | ack_hit) & (rd_s | wr_s);

  // Stall on the first cycle of a waited access and while in WAIT.
  assign stall =
    ((state_q == IDLE) & acc & ~ack_hit & HAS_WAIT) |
    ((state_q == WAIT) & acc);

  assign wait_n = ~reset_n | ~stall;
  assign commit = reset_n & acc & ~stall;

  assign io_regs = io_q;

  // Wait-state sequencer; cnt_q counts stall cycles still to come.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (acc && !ack_hit && HAS_WAIT) begin
            cnt_q <= CNT_INIT;
            if (ONE_WAIT) state_q <= DONE;
            else          state_q <= WAIT;
          end
        end
        WAIT: begin
          if (!acc) begin
            state_q <= IDLE;
          end else if (cnt_q == 3'd1) begin
            state_q <= DONE;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q - 3'd1;
          end
        end
        DONE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // RAM write port, only on the completing cycle.
  always_ff @(posedge clk) begin
    if (commit && ram_hit && wr_s)
      mem[A[ADDR_BITS-1:0]] <= cpu_dout;
  end

  // Registered RAM read; A is stable from T1 so this is ready in T2.
  always_ff @(posedge clk) begin
    if (!reset_n) mem_q <= '0;
    else          mem_q <= mem[A[ADDR_BITS-1:0]];
  end

  // I/O register file writes.
  always_ff @(posedge clk) begin
    if (!reset_n)
      io_q <= '0;
    else if (commit && io_hit && wr_s)
      io_q[A[1:0]] <= cpu_dout;
  end

  // Read-data mux back to the CPU.
  always_comb begin
    di = 8'hFF;
    if (acc && rd_s) begin
      unique case (1'b1)
        ram_hit: di = mem_q;
        io_hit:  di = io_q[A[1:0]];
        ack_hit: di = INT_VECTOR;
        default: di = 8'hFF;
      endcase
    end
  end

endmodule
